alu_bist: RTL and testbench
===========================

Name: alu_bist

Overview:
- Built-in self-test initiator for the combinational RV32I ALU. It drives the ALU operand/select inputs and consumes the ALU result.
- It generates pseudo-random operand pairs with an LFSR and walks every ALU select code for each pair.
- It compresses every result into a MISR signature and compares the final signature against a golden value.
- It sits beside the ALU in the CPU. A mux in the datapath gives it control of the ALU during test.

Parameters:
- PATTERNS, 16: number of operand pairs; legal range 1..4096.
- SEED, 32'hACE1_2468: LFSR start value; must be non-zero.
- GOLDEN, 32'h0000_0000: expected final signature.

Ports:
- I_clk  input  1  rising-edge clock
- I_rst  input  1  asynchronous, active-low reset
- I_start  input  1  start request, sampled in IDLE only
- I_result  input  32  ALU O_data for the currently presented vector
- O_alusel  output  4  ALU select, wired to ALU I_alusel
- O_data1  output  32  operand 1, wired to ALU I_data1
- O_data2  output  32  operand 2, wired to ALU I_data2
- O_busy  output  1  high while vectors are being applied
- O_done  output  1  one-cycle pulse at end of run
- O_pass  output  1  final signature == GOLDEN; valid from O_done onward
- O_signature  output  32  current MISR value

Behaviour:
- Reset (I_rst low, asynchronous):
  - state=IDLE; LFSR=SEED; MISR=0; op index=0; pattern count=0.
  - O_alusel=`ALU_ADD; O_data1=SEED; O_data2=f(SEED).
  - O_busy=0; O_done=0; O_pass=0; O_signature=0.
- Operand function: f(x) = {x[15:0],x[31:16]} ^ 32'h5A5A_5A5A. O_data1 = LFSR state; O_data2 = f(LFSR state). All outputs are registered.
- Op order, using codes from alu_definitions.vh: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI (11 ops). The op index is the inner loop; the pattern is the outer loop.
- LFSR step: Galois, poly 32'h8020_0003 (x^32+x^22+x^2+x+1).
  - next = {s[30:0],1'b0} ^ (s[31] ? POLY : 0).
  - Steps once, only on the cycle the LUI vector is consumed.
- MISR step, same poly: next = {m[30:0],1'b0} ^ (m[31] ? POLY : 0) ^ I_result.
  - Updates on every RUN cycle using I_result sampled at that edge.
  - The ALU is combinational, so the result matches the vector presented that cycle.
- States:
  - IDLE: O_busy=0. I_start=1 at an edge → RUN. On that edge: LFSR=SEED, MISR=0, op=ADD, count=0, O_pass=0; vector 0 is presented from the next cycle.
  - RUN: O_busy=1. Each edge consumes one vector: MISR update, then advance op.
    - After LUI: op=ADD, LFSR steps, count++.
    - Consuming the final LUI (count==PATTERNS-1) → DONE.
    - RUN lasts exactly 11*PATTERNS cycles.
  - DONE: lasts one cycle. O_done=1, O_busy=0, O_pass=(MISR==GOLDEN), then → IDLE.
- Hold rules: O_pass and O_signature hold until the next accepted start. O_alusel/O_data hold the last vector while idle.
- Timing: start sampled at edge 0 → O_busy high in cycles 1..11P → O_done high in cycle 11P+1.
- I_start in RUN or DONE is ignored, with no queuing. I_start held high in IDLE re-triggers immediately after DONE.
- Reset mid-run aborts with no O_done and returns all outputs to their reset values.
- Count widths are sized for PATTERNS up to 4096; wrap-around must not occur inside a legal run.

Decomposition:
- Shared header alu_bist_definitions.vh:
  - BIST_POLY
  - BIST_NUM_OPS = 11
  - XOR mask 32'h5A5A_5A5A
  - state encodings IDLE/RUN/DONE
- Op sequencing reuses the `ALU_* codes from alu_definitions.vh.
- Sub-module bist_misr32 (I_clk, I_rst, I_load, I_load_val, I_en, I_data, O_value), instantiated twice:
  - as the MISR, with I_data=I_result;
  - as the operand LFSR, with I_data=0.

Test Plan:
- Reset release → O_busy=0, O_done=0, O_pass=0, O_signature=0, O_alusel=`ALU_ADD, O_data1=32'hACE1_2468, O_data2=f(32'hACE1_2468).
- PATTERNS=1, real ALU attached, I_start pulse:
  - 11 RUN cycles with ops in listed order.
  - O_data2 = f(O_data1) throughout.
  - O_done in cycle 12; O_signature equals the bench MISR model.
- PATTERNS=16, GOLDEN set to the model signature:
  - O_done exactly 177 cycles after start.
  - O_pass=1, holding until the next start.
- Same as the previous run, but the bench XORs 32'h1 into I_result on the SRA vector of pattern 5 → O_pass=0 and the signature differs from GOLDEN.
- I_start pulsed mid-RUN → ignored: completion cycle and signature are unchanged.
- I_rst low at RUN cycle 50 → all outputs at reset values, no O_done.
  - A new start afterwards gives a signature identical to a clean run.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg: ALU select codes plus BIST polynomial, operand mask and state encoding.
package alu_bist_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [31:0] BIST_POLY = 32'h8020_0003;
  localparam int BIST_NUM_OPS = 11;
  localparam logic [31:0] BIST_MASK = 32'h5A5A_5A5A;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [31:0] misr_step(input logic [31:0] m, input logic [31:0] d);
    return {m[30:0], 1'b0} ^ (m[31] ? BIST_POLY : 32'h0) ^ d;
  endfunction
  function automatic logic [31:0] operand2(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ BIST_MASK;
  endfunction
endpackage

// File: rtl/bist_misr32.sv
// bist_misr32: 32-bit Galois MISR; with I_data tied to zero it is a plain LFSR.
module bist_misr32
  import alu_bist_pkg::*;
#(
  parameter logic [31:0] RST_VAL = 32'h0
)(
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_load,
  input  logic [31:0] I_load_val,
  input  logic        I_en,
  input  logic [31:0] I_data,
  output logic [31:0] O_value
);
  always_ff @(posedge I_clk or negedge I_rst)
    if (!I_rst) O_value <= RST_VAL;
    else if (I_load) O_value <= I_load_val;
    else if (I_en) O_value <= misr_step(O_value, I_data);
endmodule

// File: rtl/alu_bist.sv
// alu_bist: walks every ALU op over LFSR operand pairs, compresses results into a
// MISR and compares the final signature with GOLDEN.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int          PATTERNS = 16,
  parameter logic [31:0] SEED     = 32'hACE1_2468,
  parameter logic [31:0] GOLDEN   = 32'h0000_0000
)(
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_start,
  input  logic [31:0] I_result,
  output logic [3:0]  O_alusel,
  output logic [31:0] O_data1,
  output logic [31:0] O_data2,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_pass,
  output logic [31:0] O_signature
);
  state_t state, state_nx;
  logic [12:0] count;
  logic accept, last_op, last_pat, finish, lfsr_en;
  assign accept   = state == IDLE && I_start;
  assign last_op  = O_alusel == ALU_LUI;
  assign last_pat = count == 13'(PATTERNS - 1);
  assign finish   = state == RUN && last_op && last_pat;
  // the final pattern's LUI vector stays on the ALU inputs while idle
  assign lfsr_en  = state == RUN && last_op && !last_pat;
  assign O_busy   = state == RUN;
  assign O_done   = state == DONE;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = RUN;
    else if (finish) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge I_clk or negedge I_rst)
    if (!I_rst) begin
      state    <= IDLE;
      count    <= '0;
      O_alusel <= ALU_ADD;
      O_data2  <= operand2(SEED);
      O_pass   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        count    <= '0;
        O_alusel <= ALU_ADD;
        O_data2  <= operand2(SEED);
        O_pass   <= 1'b0;
      end else if (state == RUN) begin
        if (!finish) O_alusel <= last_op ? ALU_ADD : O_alusel + 4'd1;
        if (lfsr_en) begin
          count   <= count + 13'd1;
          O_data2 <= operand2(misr_step(O_data1, 32'h0));
        end
        if (finish) O_pass <= misr_step(O_signature, I_result) == GOLDEN;
      end
    end
  bist_misr32 #(.RST_VAL(32'h0)) u_misr (
    .I_clk(I_clk), .I_rst(I_rst), .I_load(accept), .I_load_val(32'h0),
    .I_en(state == RUN), .I_data(I_result), .O_value(O_signature)
  );
  bist_misr32 #(.RST_VAL(SEED)) u_lfsr (
    .I_clk(I_clk), .I_rst(I_rst), .I_load(accept), .I_load_val(SEED),
    .I_en(lfsr_en), .I_data(32'h0), .O_value(O_data1)
  );
endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: checks alu_bist against a pattern/op-indexed model driven by an ALU model.
module tb_alu_bist;
  import alu_bist_pkg::*;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam int P16 = 16;
  localparam logic [43:0] OPS = {ALU_LUI, ALU_AND, ALU_OR, ALU_SRA, ALU_SRL, ALU_XOR,
                                 ALU_SLTU, ALU_SLT, ALU_SLL, ALU_SUB, ALU_ADD};
  function automatic logic [3:0] op_at(input int k);
    return OPS[k*4 +: 4];
  endfunction
  function automatic logic [31:0] f(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h5A5A_5A5A;
  endfunction
  function automatic logic [31:0] lstep(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h8020_0003 : 32'h0);
  endfunction
  function automatic logic [31:0] mstep(input logic [31:0] m, input logic [31:0] d);
    return lstep(m) ^ d;
  endfunction
  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_LUI:  return b;
      default:  return 32'h0;
    endcase
  endfunction
  function automatic logic [31:0] model_sig(input int p, input int fp);
    logic [31:0] a, m;
    m = 32'h0;
    a = SEED;
    for (int i = 0; i < p; i++) begin
      for (int k = 0; k < 11; k++)
        m = mstep(m, alu(op_at(k), a, f(a)) ^ ((i == fp && op_at(k) == ALU_SRA) ? 32'h1 : 32'h0));
      a = lstep(a);
    end
    return m;
  endfunction
  localparam logic [31:0] GOLD16 = model_sig(P16, -1);

  logic clk = 1'b0, rst_n = 1'b0, start1 = 1'b0, start16 = 1'b0, fault = 1'b0;
  logic [3:0] sel1, sel16;
  logic [31:0] a1, b1, r1, sig1, a16, b16, r16, sig16;
  logic busy1, done1, pass1, busy16, done16, pass16;
  logic [31:0] pat_a [P16];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;

  assign r1  = alu(sel1, a1, b1);
  assign r16 = alu(sel16, a16, b16) ^ ((fault && sel16 == ALU_SRA && a16 == pat_a[5]) ? 32'h1 : 32'h0);

  alu_bist #(.PATTERNS(1), .SEED(SEED), .GOLDEN(32'h0)) dut1 (
    .I_clk(clk), .I_rst(rst_n), .I_start(start1), .I_result(r1), .O_alusel(sel1),
    .O_data1(a1), .O_data2(b1), .O_busy(busy1), .O_done(done1), .O_pass(pass1), .O_signature(sig1)
  );
  alu_bist #(.PATTERNS(P16), .SEED(SEED), .GOLDEN(GOLD16)) dut16 (
    .I_clk(clk), .I_rst(rst_n), .I_start(start16), .I_result(r16), .O_alusel(sel16),
    .O_data1(a16), .O_data2(b16), .O_busy(busy16), .O_done(done16), .O_pass(pass16), .O_signature(sig16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle model of the 16-pattern instance, indexed by run cycle k
  initial begin : model_p
    int run_k;
    logic e_done, e_pass;
    logic [31:0] e_sig, e_d1, res;
    logic [3:0] e_op;
    run_k = -1; e_done = 0; e_pass = 0; e_sig = 0; e_op = ALU_ADD; e_d1 = SEED;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_k = -1; e_done = 0; e_pass = 0; e_sig = 0; e_op = ALU_ADD; e_d1 = SEED;
      end
      check("busy", 32'(busy16), 32'(run_k >= 0));
      check("done", 32'(done16), 32'(e_done));
      check("pass", 32'(pass16), 32'(e_pass));
      check("signature", sig16, e_sig);
      check("alusel", 32'(sel16), 32'(e_op));
      check("data1", a16, e_d1);
      check("data2", b16, f(e_d1));
      if (rst_n) begin
        if (e_done) e_done = 0;
        else if (run_k >= 0) begin
          res = alu(e_op, e_d1, f(e_d1)) ^ ((fault && run_k / 11 == 5 && e_op == ALU_SRA) ? 32'h1 : 32'h0);
          e_sig = mstep(e_sig, res);
          run_k++;
          if (run_k == 11 * P16) begin
            run_k = -1; e_done = 1; e_pass = e_sig == GOLD16;
          end else begin
            e_op = op_at(run_k % 11); e_d1 = pat_a[run_k / 11];
          end
        end else if (start16) begin
          run_k = 0; e_sig = 0; e_pass = 0; e_op = ALU_ADD; e_d1 = SEED;
        end
      end
    end
  end

  task automatic run16(input int mid, output int cyc);
    @(posedge clk); #1 start16 = 1;
    @(posedge clk); #1 start16 = 0;
    cyc = 0;
    for (int i = 1; i <= 400 && cyc == 0; i++) begin
      @(negedge clk);
      if (done16) cyc = i;
      if (i == mid) #2 start16 = 1;
      else if (i == mid + 1) #2 start16 = 0;
    end
  endtask

  initial begin : stim
    int cyc;
    logic seen;
    pat_a[0] = SEED;
    for (int i = 1; i < P16; i++) pat_a[i] = lstep(pat_a[i-1]);
    check("pin_f", f(SEED), 32'h7E32_F6BB);
    check("pin_lfsr", pat_a[1], 32'hD9E2_48D3);
    check("pin_sub", alu(ALU_SUB, 32'h1, 32'h2), 32'hFFFF_FFFF);
    check("pin_sra", alu(ALU_SRA, 32'h8000_0000, 32'h4), 32'hF800_0000);
    check("pin_slt", alu(ALU_SLT, 32'hFFFF_FFFF, 32'h0), 32'h1);
    check("pin_sltu", alu(ALU_SLTU, 32'hFFFF_FFFF, 32'h0), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_busy", 32'(busy16), 32'h0);
    check("rst_signature", sig16, 32'h0);
    check("rst_alusel", 32'(sel16), 32'(ALU_ADD));
    check("rst_data1", a16, 32'hACE1_2468);
    check("rst_data2", b16, 32'h7E32_F6BB);
    // single pattern run
    @(posedge clk); #1 start1 = 1;
    @(posedge clk); #1 start1 = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      check("p1_busy", 32'(busy1), 32'h1);
      check("p1_alusel", 32'(sel1), 32'(op_at(c - 1)));
      check("p1_data1", a1, SEED);
      check("p1_data2", b1, f(a1));
    end
    @(negedge clk);
    check("p1_done", 32'(done1), 32'h1);
    check("p1_busy_end", 32'(busy1), 32'h0);
    check("p1_signature", sig1, model_sig(1, -1));
    check("p1_pass", 32'(pass1), 32'(model_sig(1, -1) == 32'h0));
    // clean 16-pattern run, pass must hold
    run16(-5, cyc);
    check("p16_done_cycle", cyc, 177);
    check("p16_pass", 32'(pass16), 32'h1);
    repeat (5) @(negedge clk);
    check("p16_pass_hold", 32'(pass16), 32'h1);
    check("p16_sig_hold", sig16, GOLD16);
    // single-bit fault on SRA of pattern 5
    fault = 1;
    run16(-5, cyc);
    check("fault_done_cycle", cyc, 177);
    check("fault_pass", 32'(pass16), 32'h0);
    check("fault_sig_differs", 32'(sig16 != GOLD16), 32'h1);
    check("fault_sig", sig16, model_sig(P16, 5));
    @(negedge clk);
    fault = 0;
    // start pulse mid-run is ignored
    run16(30, cyc);
    check("mid_done_cycle", cyc, 177);
    check("mid_sig", sig16, GOLD16);
    check("mid_pass", 32'(pass16), 32'h1);
    // reset during RUN cycle 50
    @(posedge clk); #1 start16 = 1;
    @(posedge clk); #1 start16 = 0;
    repeat (49) @(negedge clk);
    @(posedge clk); #1 rst_n = 0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done16) seen = 1;
    end
    check("abort_no_done", 32'(seen), 32'h0);
    check("abort_busy", 32'(busy16), 32'h0);
    check("abort_pass", 32'(pass16), 32'h0);
    check("abort_sig", sig16, 32'h0);
    check("abort_data2", b16, 32'h7E32_F6BB);
    @(posedge clk); #1 rst_n = 1;
    run16(-5, cyc);
    check("rerun_done_cycle", cyc, 177);
    check("rerun_sig", sig16, GOLD16);
    check("rerun_pass", 32'(pass16), 32'h1);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
